// File: rtl/te_srsc_pipe.sv
// Transmission estimation and scene recovery for the dehaze datapath.
// Five-stage ready/valid pipeline with a global stall enable and frame-end tagging.
module te_srsc_pipe #(
  parameter int CH      = 3,
  parameter int DATA_W  = 8,
  parameter int INV_W   = 10,
  parameter int OMEGA   = 243,
  parameter int T0      = 26,
  parameter int IMG_PIX = 262144
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CH*DATA_W-1:0]   in_pix,
  input  logic [CH*DATA_W-1:0]   in_filt,
  input  logic [CH*DATA_W-1:0]   in_a,
  input  logic [CH*INV_W-1:0]    in_inv_a,
  input  logic [1:0]             in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CH*DATA_W-1:0]   out_pix,
  output logic                   out_last
);

  localparam int PW    = CH * DATA_W;
  localparam int MW    = DATA_W + 5;
  localparam int PRW   = DATA_W + INV_W;
  localparam int CNT_W = (IMG_PIX > 1) ? $clog2(IMG_PIX) : 1;
  localparam int TSH   = (DATA_W >= 8) ? DATA_W - 8 : 0;
  localparam int TSR   = (DATA_W < 8) ? 8 - DATA_W : 0;
  localparam logic [INV_W-1:0] RATIO_MAX = '1;
  localparam logic signed [DATA_W+6:0] JMAX = {7'b0, {DATA_W{1'b1}}};

  logic                en;
  logic [3:0]          vld_q, vld_d;
  logic [PW-1:0]       pix_q [4], pix_d [4];
  logic [PW-1:0]       a_q [4], a_d [4];
  logic [1:0]          mode_q [4], mode_d [4];
  logic [DATA_W-1:0]   s1_fmin_q, s1_fmin_d;
  logic [INV_W-1:0]    s1_inva_q, s1_inva_d;
  logic [INV_W-1:0]    s2_ratio_q, s2_ratio_d;
  logic [7:0]          s3_t8_q, s3_t8_d, s3_recip_q, s3_recip_d;
  logic [CH-1:0]       s4_sub_q, s4_sub_d;
  logic [MW-1:0]       s4_m_q [CH], s4_m_d [CH];
  logic [7:0]          s4_t8_q, s4_t8_d;
  logic                out_valid_q, out_valid_d;
  logic [PW-1:0]       out_pix_q, out_pix_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [DATA_W-1:0]   filt_c [CH];
  logic [INV_W-1:0]    inva_c [CH];
  logic [7:0]          recip_rom [256];

  logic [PRW-1:0]      prod2;
  logic [INV_W+7:0]    om_full;
  logic [INV_W:0]      t_full;
  logic [8:0]          t8_raw;
  logic [DATA_W-1:0]   i4, a4, d4;
  logic [DATA_W+7:0]   p4;
  logic [DATA_W-1:0]   i5, a5, t8w;
  logic [DATA_W+7:0]   t8_ext;
  logic signed [DATA_W+6:0] j5;

  assign en        = !out_valid_q || out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_pix   = out_pix_q;
  assign out_last  = out_valid_q && (cnt_q == CNT_W'(IMG_PIX - 1));

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_unpack
      assign filt_c[gi] = in_filt[(CH-gi)*DATA_W-1 -: DATA_W];
      assign inva_c[gi] = in_inv_a[(CH-gi)*INV_W-1 -: INV_W];
    end
    // Q4.4 reciprocal of t8; saturates where 4096/t8 would not fit in 8 bits.
    for (gi = 0; gi < 256; gi++) begin : g_rom
      localparam int RV = (gi == 0) ? 255 : 4096 / gi;
      assign recip_rom[gi] = (gi < T0) ? 8'd0 : ((RV > 255) ? 8'd255 : 8'(RV));
    end
  endgenerate

  always_comb begin
    vld_d     = {vld_q[2:0], in_valid};
    pix_d[0]  = in_pix;
    a_d[0]    = in_a;
    mode_d[0] = in_mode;
    for (int s = 1; s < 4; s++) begin
      pix_d[s]  = pix_q[s-1];
      a_d[s]    = a_q[s-1];
      mode_d[s] = mode_q[s-1];
    end
  end

  // Strict compare keeps the lowest channel index on ties.
  always_comb begin
    s1_fmin_d = filt_c[0];
    s1_inva_d = inva_c[0];
    for (int c = 1; c < CH; c++) begin
      if (filt_c[c] < s1_fmin_d) begin
        s1_fmin_d = filt_c[c];
        s1_inva_d = inva_c[c];
      end
    end
  end

  always_comb begin
    prod2      = PRW'(s1_fmin_q) * PRW'(s1_inva_q);
    s2_ratio_d = (prod2 > PRW'(RATIO_MAX)) ? RATIO_MAX : INV_W'(prod2);
  end

  always_comb begin
    om_full = (INV_W+8)'(s2_ratio_q) * (INV_W+8)'(OMEGA);
    t_full  = (INV_W+1)'(1 << INV_W) - (INV_W+1)'(om_full >> 8);
    t8_raw  = 9'(t_full >> (INV_W - 8));
    s3_t8_d = (t8_raw > 9'd255) ? 8'd255 : 8'(t8_raw);
    if (s3_t8_d < 8'(T0)) s3_t8_d = 8'(T0);
    s3_recip_d = recip_rom[s3_t8_d];
  end

  always_comb begin
    s4_t8_d  = s3_t8_q;
    s4_sub_d = '0;
    i4 = '0;
    a4 = '0;
    d4 = '0;
    p4 = '0;
    for (int c = 0; c < CH; c++) begin
      i4          = pix_q[2][(CH-c)*DATA_W-1 -: DATA_W];
      a4          = a_q[2][(CH-c)*DATA_W-1 -: DATA_W];
      s4_sub_d[c] = i4 < a4;
      d4          = s4_sub_d[c] ? (a4 - i4) : (i4 - a4);
      p4          = (DATA_W+8)'(d4) * (DATA_W+8)'(s3_recip_q);
      s4_m_d[c]   = MW'(p4 >> 4);
    end
  end

  always_comb begin
    out_valid_d = vld_q[3];
    out_pix_d   = '0;
    t8_ext      = (DATA_W+8)'(s4_t8_q);
    t8w         = DATA_W'((t8_ext << TSH) >> TSR);
    i5 = '0;
    a5 = '0;
    j5 = '0;
    for (int c = 0; c < CH; c++) begin
      i5 = pix_q[3][(CH-c)*DATA_W-1 -: DATA_W];
      a5 = a_q[3][(CH-c)*DATA_W-1 -: DATA_W];
      if (s4_sub_q[c]) j5 = signed'({7'b0, a5}) - signed'({2'b0, s4_m_q[c]});
      else             j5 = signed'({7'b0, a5}) + signed'({2'b0, s4_m_q[c]});
      case (mode_q[3])
        2'd1:    out_pix_d[(CH-c)*DATA_W-1 -: DATA_W] = i5;
        2'd2:    out_pix_d[(CH-c)*DATA_W-1 -: DATA_W] = t8w;
        default: begin
          if (j5[DATA_W+6])  out_pix_d[(CH-c)*DATA_W-1 -: DATA_W] = '0;
          else if (j5 > JMAX) out_pix_d[(CH-c)*DATA_W-1 -: DATA_W] = '1;
          else               out_pix_d[(CH-c)*DATA_W-1 -: DATA_W] = DATA_W'(j5);
        end
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (out_valid_q && out_ready)
      cnt_d = (cnt_q == CNT_W'(IMG_PIX - 1)) ? '0 : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q       <= '0;
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      cnt_q       <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (en) begin
        vld_q       <= vld_d;
        pix_q       <= pix_d;
        a_q         <= a_d;
        mode_q      <= mode_d;
        s1_fmin_q   <= s1_fmin_d;
        s1_inva_q   <= s1_inva_d;
        s2_ratio_q  <= s2_ratio_d;
        s3_t8_q     <= s3_t8_d;
        s3_recip_q  <= s3_recip_d;
        s4_sub_q    <= s4_sub_d;
        s4_m_q      <= s4_m_d;
        s4_t8_q     <= s4_t8_d;
        out_valid_q <= out_valid_d;
        out_pix_q   <= out_pix_d;
      end
    end
  end

endmodule

// File: tb/tb_te_srsc_pipe.sv
// Self-checking bench for te_srsc_pipe: fixed vectors, random beats under backpressure,
// frame tagging and mid-stream reset, all checked through an ordered scoreboard.
module tb_te_srsc_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_last;
  logic [23:0] in_pix, in_filt, in_a, out_pix;
  logic [29:0] in_inv_a;
  logic [1:0]  in_mode;

  always #5 clk = ~clk;

  te_srsc_pipe #(.IMG_PIX(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pix(in_pix), .in_filt(in_filt), .in_a(in_a), .in_inv_a(in_inv_a),
    .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_pix(out_pix), .out_last(out_last)
  );

  typedef struct {
    logic [23:0] pix, filt, a;
    logic [29:0] inva;
    logic [1:0]  mode;
    logic [23:0] exp;
  } vec_t;

  typedef struct {
    logic [23:0] pix;
    int          acc_n;
    bit          lat;
  } sb_t;

  vec_t        tbl [11];
  sb_t         sb [$];
  int          last_hits [$];
  int          chk_cnt = 0, err_cnt = 0;
  int          n = 0, exp_cnt = 0, out_idx = 0;
  logic [23:0] cur_exp = '0;
  bit          cur_lat = 1'b0;
  bit          held = 1'b0;
  logic [23:0] held_pix;
  logic        held_last;
  bit          bp_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [23:0] p3(input int x, input int y, input int z);
    return {x[7:0], y[7:0], z[7:0]};
  endfunction

  function automatic logic [29:0] q3(input int x, input int y, input int z);
    return {x[9:0], y[9:0], z[9:0]};
  endfunction

  // Integer reference of the transmission/recovery arithmetic.
  function automatic logic [23:0] model(input logic [23:0] p, input logic [23:0] f,
                                        input logic [23:0] a, input logic [29:0] ia,
                                        input logic [1:0] m);
    int fv[3], iv[3], av[3], pv[3];
    int k, prod, ratio, om, t, t8, rc, j;
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++) begin
      fv[c] = int'(f[23-8*c -: 8]);
      av[c] = int'(a[23-8*c -: 8]);
      pv[c] = int'(p[23-8*c -: 8]);
      iv[c] = int'(ia[29-10*c -: 10]);
    end
    k = 0;
    for (int c = 1; c < 3; c++) if (fv[c] < fv[k]) k = c;
    prod  = fv[k] * iv[k];
    ratio = (prod > 1023) ? 1023 : prod;
    om    = (ratio * 243) / 256;
    t     = 1024 - om;
    t8    = t / 4;
    if (t8 > 255) t8 = 255;
    if (t8 < 26) t8 = 26;
    rc = 4096 / t8;
    if (rc > 255) rc = 255;
    for (int c = 0; c < 3; c++) begin
      if (m == 2'd1) j = pv[c];
      else if (m == 2'd2) j = t8;
      else begin
        if (pv[c] < av[c]) j = av[c] - ((av[c] - pv[c]) * rc) / 16;
        else               j = av[c] + ((pv[c] - av[c]) * rc) / 16;
        if (j < 0) j = 0;
        if (j > 255) j = 255;
      end
      r[23-8*c -: 8] = j[7:0];
    end
    return r;
  endfunction

  always @(negedge clk) begin
    sb_t e;
    n++;
    if (!rst_n) begin
      sb.delete();
      exp_cnt = 0;
      out_idx = 0;
      held    = 1'b0;
    end else begin
      check("in_ready_en", 32'(in_ready), 32'(!out_valid || out_ready));
      if (held) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_pix", 32'(out_pix), 32'(held_pix));
        check("hold_last", 32'(out_last), 32'(held_last));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL unexpected_output: got %06h, expected none", out_pix);
        end else begin
          e = sb.pop_front();
          check("out_pix", 32'(out_pix), 32'(e.pix));
          if (e.lat) check("latency", 32'(n - e.acc_n), 32'd5);
        end
        check("out_last", 32'(out_last), 32'(exp_cnt == 15));
        if (out_last) last_hits.push_back(out_idx);
        $display("out %0d: pix=%06h last=%0b", out_idx, out_pix, out_last);
        exp_cnt = (exp_cnt + 1) % 16;
        out_idx++;
      end
      held      = out_valid && !out_ready;
      held_pix  = out_pix;
      held_last = out_last;
      if (in_valid && in_ready) sb.push_back('{pix: cur_exp, acc_n: n, lat: cur_lat});
    end
  end

  task automatic send(input logic [23:0] p, input logic [23:0] f, input logic [23:0] a,
                      input logic [29:0] ia, input logic [1:0] m, input logic [23:0] e);
    int w;
    in_pix = p; in_filt = f; in_a = a; in_inv_a = ia; in_mode = m;
    cur_exp  = e;
    in_valid = 1'b1;
    w = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      w++;
      if (w > 100) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL send_timeout: got in_ready=0, expected 1 within 100 cycles");
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand(input bit mode0);
    logic [23:0] rp, rf, ra;
    logic [29:0] ri;
    logic [1:0]  rm;
    rp = 24'($urandom);
    rf = 24'($urandom);
    ra = 24'($urandom);
    ri = 30'($urandom);
    rm = mode0 ? 2'd0 : 2'($urandom_range(0, 3));
    send(rp, rf, ra, ri, rm, model(rp, rf, ra, ri, rm));
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_pix = '0; in_filt = '0; in_a = '0; in_inv_a = '0; in_mode = '0;

    tbl[0]  = '{p3(200,150,100), p3(180,120,90), p3(220,220,220), q3(5,5,5), 2'd0, p3(187,102,18)};
    tbl[1]  = '{p3(200,150,100), p3(180,120,90), p3(220,220,220), q3(5,5,5), 2'd1, p3(200,150,100)};
    tbl[2]  = '{p3(200,150,100), p3(180,120,90), p3(220,220,220), q3(5,5,5), 2'd2, p3(149,149,149)};
    tbl[3]  = '{p3(200,150,100), p3(180,120,90), p3(220,220,220), q3(5,5,5), 2'd3, p3(187,102,18)};
    tbl[4]  = '{p3(0,0,0), p3(255,255,255), p3(255,255,255), q3(4,4,4), 2'd0, p3(0,0,0)};
    tbl[5]  = '{p3(0,0,0), p3(255,255,255), p3(255,255,255), q3(4,4,4), 2'd2, p3(26,26,26)};
    tbl[6]  = '{p3(255,255,255), p3(50,50,50), p3(50,50,50), q3(20,20,20), 2'd0, p3(255,255,255)};
    tbl[7]  = '{p3(255,255,255), p3(0,0,0), p3(100,100,100), q3(10,10,10), 2'd0, p3(255,255,255)};
    tbl[8]  = '{p3(255,255,255), p3(0,0,0), p3(100,100,100), q3(10,10,10), 2'd2, p3(255,255,255)};
    tbl[9]  = '{p3(200,150,100), p3(90,120,90), p3(220,220,220), q3(5,9,9), 2'd0, p3(187,102,18)};
    tbl[10] = '{p3(10,200,60), p3(100,40,70), p3(120,180,90), q3(8,6,11), 2'd0, p3(0,205,53)};

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_pix", 32'(out_pix), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // Back-to-back table beats, alternating modes, with latency tracked on each.
    cur_lat = 1'b1;
    for (int i = 0; i < 11; i++)
      send(tbl[i].pix, tbl[i].filt, tbl[i].a, tbl[i].inva, tbl[i].mode, tbl[i].exp);
    drain();
    cur_lat = 1'b0;

    // Random beats under a 2-on/3-off out_ready pattern.
    bp_done = 1'b0;
    fork
      begin : snd
        for (int i = 0; i < 20; i++) send_rand(1'b0);
        bp_done = 1'b1;
      end
      begin : tog
        int ph;
        ph = 0;
        for (int g = 0; g < 2000 && !bp_done; g++) begin
          @(posedge clk); #1;
          out_ready = (ph < 2);
          ph = (ph + 1) % 5;
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Frame tagging over 40 beats from a fresh reset.
    do_reset();
    last_hits.delete();
    for (int i = 0; i < 40; i++) send_rand(1'b1);
    drain();
    check("frame_last_count", 32'(last_hits.size()), 32'd2);
    if (last_hits.size() == 2) begin
      check("frame_last_pos0", 32'(last_hits[0]), 32'd15);
      check("frame_last_pos1", 32'(last_hits[1]), 32'd31);
    end

    // One-cycle reset in the middle of a stream.
    for (int i = 0; i < 32; i++) begin
      if (i == 12) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        last_hits.delete();
        @(posedge clk); #1;
      end
      send_rand(1'b1);
    end
    drain();
    check("midrst_last_count", 32'(last_hits.size()), 32'd1);
    if (last_hits.size() == 1) check("midrst_last_pos", 32'(last_hits[0]), 32'd15);

    $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/te_srsc_pipe.md
Name: te_srsc_pipe

Overview:
- Parametrised successor to the fixed 3-channel transmission-estimation and scene-recovery stage of the dehaze datapath.
- Consumes, per pixel: the centre pixel, the per-channel window-filtered values from the upstream edge-adaptive filter, and the atmospheric light per channel.
- Estimates transmission t = 1 - ω·min_c(F_c/A_c), clamped to T0, and recovers J_c = A_c ± |I_c - A_c|/t with saturation.
- Adds ready/valid backpressure, channel-count and width generalisation, runtime bypass/debug modes, and frame-end tagging.

Parameters:
- CH, 3, channel count (1..4).
- DATA_W, 8, bits per channel sample.
- INV_W, 10, fraction bits of inverse atmospheric light (Q0.INV_W); must be ≥ 8.
- OMEGA, 243, haze-retention factor ω in Q0.8 (243 ≈ 0.95).
- T0, 26, lower bound on quantised transmission t8 (Q0.8, 26 ≈ 0.1); range 1..255.
- IMG_PIX, 262144, pixels per frame (512·512).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&&in_ready
- in_pix  in  CH*DATA_W  centre pixel I; channel 0 in MSBs
- in_filt  in  CH*DATA_W  filtered window values F_c
- in_a  in  CH*DATA_W  atmospheric light A_c
- in_inv_a  in  CH*INV_W  1/A_c, Q0.INV_W
- in_mode  in  2  0 = dehaze, 1 = bypass (J = I), 2 = t-map (every channel = t8 scaled to DATA_W), 3 = reserved, behaves as 0
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_pix  out  CH*DATA_W  recovered pixel J
- out_last  out  1  high with the final pixel of each frame

Behaviour:
- Reset (rst_n=0 at a clk edge): all stage valid bits clear; out_valid=0, out_pix=0, out_last=0; frame counter=0. in_ready is 1 while rst_n=1 and the pipeline is empty. Reset mid-frame discards every in-flight beat; the next accepted beat is pixel 0.
- Pipeline: 5 register stages with global enable en = !out_valid || out_ready; in_ready = en. On stall, every stage holds its contents and bubbles are not compressed. Latency with out_ready=1 is exactly 5 cycles from acceptance to out_valid. Throughput is 1 pixel/clk.
- S1: select k = argmin_c F_c; ties go to the lowest channel index. Register Fmin = F_k, invA = inv_a_k, plus I, A, mode.
- S2: prod = Fmin·invA (DATA_W+INV_W bits); ratio = min(prod, 2^INV_W-1).
- S3:
  - om = (ratio·OMEGA)>>8
  - t = 2^INV_W - om
  - t8 = min(t>>(INV_W-8), 255)
  - t8 = max(t8, T0)
  - recip = floor(4096/t8), Q4.4, 8 bits; implemented as a 256-entry constant ROM (entries below T0 unused).
- S4, per channel:
  - sub_c = (I_c < A_c)
  - d_c = |I_c - A_c|
  - m_c = (d_c·recip)>>4, held at DATA_W+5 bits.
- S5, per channel: J_c = sub_c ? A_c - m_c : A_c + m_c, computed signed and saturated to [0, 2^DATA_W-1]. The mode mux then selects the output: mode 1 gives I, mode 2 gives t8 replicated (t8<<(DATA_W-8)), otherwise J. Result is registered into out_pix.
- Mode, A and inv_a are sampled per beat and travel with it, so a change between consecutive pixels affects only later pixels.
- Frame counter: increments on each output handshake (out_valid&&out_ready). out_last = (counter == IMG_PIX-1) while out_valid. After the handshake of the last pixel the counter wraps to 0.
- While out_valid&&!out_ready, out_pix, out_last and out_valid are held stable.

Test Plan:
- CH=3, DATA_W=8, I=(200,150,100), F=(180,120,90), A=(220,220,220), inv_a=(5,5,5), mode 0 -> k=2, ratio=450, t=597, t8=149, recip=27; out_pix=(187,102,18) exactly 5 cycles after acceptance.
- Clamp/underflow: I=(0,0,0), F=(255,255,255), A=(255,255,255), inv_a=4 -> t8=14 clamped to 26, recip=157; out_pix=(0,0,0).
- Overflow saturation: I=(255,255,255), F=(50,50,50), A=(50,50,50), inv_a=20 -> t8 clamped to 26; out_pix=(255,255,255). Also F=(0,0,0), A=100, inv_a=10, I=255 -> t8=255, recip=16; out=(255,255,255).
- Modes: the first vector with mode 1 -> (200,150,100); with mode 2 -> (149,149,149). Alternate modes on back-to-back beats; each output must match its own beat's mode.
- Backpressure: stream 20 random beats while toggling out_ready in a 2-cycle-on/3-cycle-off pattern -> no loss or duplication, outputs in order, held stable while stalled, in_ready==en every cycle.
- Frame/reset: IMG_PIX=16, stream 40 beats -> out_last on beats 15 and 31. Assert rst_n=0 for one cycle mid-stream -> out_valid=0 next cycle, and the next output after restart is counted as pixel 0.
